bram_port_arbiter: RTL

Round-robin access arbiter that shares one simple dual-port block RAM (1024 × 8, port A write-only, port B read-only, common clock) among NREQ requesters. Each requester issues single-beat reads or writes over a valid/ready handshake. The block grants port A and port B independently, blocks same-cycle same-address read/write collisions, and returns read data with a per-requester response strobe after the fixed BRAM read latency. It sits between the requesting engines and the BRAM IP instance, and is the only driver of the BRAM's port signals.

---
 rtl/bram_port_arbiter_pkg.sv | 32 +++
 rtl/bram_port_arbiter_if.sv | 26 ++
 rtl/bram_port_arbiter_rr_pick.sv | 36 +++
 rtl/bram_port_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants, response tag payload and helpers for the BRAM port arbiter.
package bram_port_arbiter_pkg;

  localparam int unsigned NREQ_DEF = 2;
  localparam int unsigned AW_DEF   = 10;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned RL_DEF   = 1;

  // Upper bounds: requester ids fit in 2 bits (NREQ <= 4), compare width covers any AW used here.
  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned ID_MAX_W = 2;
  localparam int unsigned AW_MAX   = 16;

  // Requester id width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // A read is blocked when a write is granted to the same address in the same cycle.
  function automatic logic rd_blocked(input logic              wr_gnt,
                                      input logic [AW_MAX-1:0] waddr,
                                      input logic [AW_MAX-1:0] raddr);
    return wr_gnt && (waddr == raddr);
  endfunction

  // One slot of the read-response tracking pipeline.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } rsp_tag_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side request/response bundle of the BRAM port arbiter.
interface bram_port_arbiter_if
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_port_arbiter_rr_pick.sv
// Round-robin picker: first candidate at or after ptr (wrapping) wins.
module rr_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = 1
) (
  input  logic [NREQ-1:0] cand,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned     j;
  logic [ID_W-1:0] jj;

  // Scan NREQ slots starting at ptr; the first set candidate is granted.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j  = (32'(ptr) + k) % NREQ;
      jj = ID_W'(j);
      if (!any && cand[jj]) begin
        gnt[jj] = 1'b1;
        idx     = jj;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port BRAM (A write, B read) among NREQ requesters.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ         = NREQ_DEF,
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned READ_LATENCY = RL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  bram_port_arbiter_if.slave  bus,
  output logic                bram_ena,
  output logic                bram_wea,
  output logic [AW-1:0]       bram_addra,
  output logic [DW-1:0]       bram_dina,
  output logic                bram_enb,
  output logic [AW-1:0]       bram_addrb,
  input  logic [DW-1:0]       bram_doutb
);

  localparam int unsigned ID_W = id_width(NREQ);

  logic [ID_W-1:0] wptr, rptr;
  logic [NREQ-1:0] wcand, rcand, wgnt, rgnt;
  logic [ID_W-1:0] widx, ridx;
  logic            wany, rany, rd_ok;
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [AW-1:0]   waddr, raddr;

  rsp_tag_t                         tag_in;
  rsp_tag_t [READ_LATENCY-1:0]      pipe;
  rsp_tag_t                         tail;

  // Pointer value after granting idx: idx+1 modulo NREQ.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
    return (32'(idx) == NREQ - 1) ? '0 : idx + ID_W'(1);
  endfunction

  // Unpack per-requester address/data lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[i*AW +: AW];
    assign wdata_arr[i] = bus.req_wdata[i*DW +: DW];
  end

  // Split candidates per port; nothing competes while in reset.
  always_comb begin
    wcand = '0;
    rcand = '0;
    if (!rst) begin
      wcand = bus.req_valid & bus.req_we;
      rcand = bus.req_valid & ~bus.req_we;
    end
  end

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_wpick (
    .cand (wcand),
    .ptr  (wptr),
    .gnt  (wgnt),
    .idx  (widx),
    .any  (wany)
  );

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_rpick (
    .cand (rcand),
    .ptr  (rptr),
    .gnt  (rgnt),
    .idx  (ridx),
    .any  (rany)
  );

  assign waddr = addr_arr[widx];
  assign raddr = addr_arr[ridx];
  assign rd_ok = rany & ~rd_blocked(wany, AW_MAX'(waddr), AW_MAX'(raddr));

  // Ready strobes and BRAM port muxes; idle ports drive zeros.
  always_comb begin
    bus.req_ready = '0;
    bram_ena      = 1'b0;
    bram_wea      = 1'b0;
    bram_addra    = '0;
    bram_dina     = '0;
    bram_enb      = 1'b0;
    bram_addrb    = '0;
    if (wany) begin
      bus.req_ready = wgnt;
      bram_ena      = 1'b1;
      bram_wea      = 1'b1;
      bram_addra    = waddr;
      bram_dina     = wdata_arr[widx];
    end
    if (rd_ok) begin
      bus.req_ready = bus.req_ready | rgnt;
      bram_enb      = 1'b1;
      bram_addrb    = raddr;
    end
  end

  // Round-robin pointers advance past each granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wany)  wptr <= ptr_after(widx);
      if (rd_ok) rptr <= ptr_after(ridx);
    end
  end

  // Tag of the read accepted this cycle.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = rd_ok;
    tag_in.id    = ID_MAX_W'(ridx);
  end

  // Response tracking pipeline, one stage per cycle of BRAM read latency.
  if (READ_LATENCY > 1) begin : g_deep
    always_ff @(posedge clk) begin
      if (rst) pipe <= '0;
      else     pipe <= {pipe[READ_LATENCY-2:0], tag_in};
    end
  end else begin : g_shallow
    always_ff @(posedge clk) begin
      if (rst) pipe <= '0;
      else     pipe <= tag_in;
    end
  end

  assign tail = pipe[READ_LATENCY-1];

  // Decode the emerging tag into a per-requester strobe; suppressed while in reset.
  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign bus.rsp_valid[i] = !rst && tail.valid && (tail.id == ID_MAX_W'(i));
  end

  assign bus.rsp_rdata = bram_doutb;

endmodule
